// File: rtl/tile_board_engine.sv
// Scrolling tile board for the lane-tapping game: LFSR tile generator, hit-row
// judging, saturating score, speed-up schedule and an IDLE/PLAY/OVER state machine.
module tile_board_engine #(
  parameter int          LANES         = 4,
  parameter int          ROWS          = 5,
  parameter logic [23:0] SCROLL_DIV    = 24'd6_000_000,
  parameter logic [23:0] SCROLL_MIN    = 24'd1_500_000,
  parameter logic [23:0] SCROLL_STEP   = 24'd250_000,
  parameter int          SPEEDUP_EVERY = 8,
  parameter int          SCORE_W       = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LANES-1:0]         btn,
  input  logic                     start,
  output logic [LANES*ROWS-1:0]    tiles,
  output logic [SCORE_W-1:0]       score,
  output logic                     playing,
  output logic                     game_over,
  output logic                     scroll_pulse,
  output logic [1:0]               dbg_state
);

  localparam int LW    = $clog2(LANES);
  localparam int SPW   = $clog2(SPEEDUP_EVERY);
  localparam int HIT_LO = (ROWS - 1) * LANES;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [LANES*ROWS-1:0]   tiles_q, tiles_d;
  logic [SCORE_W-1:0]      score_q, score_d;
  logic                    scroll_q, scroll_d;
  logic [7:0]              lfsr_q, lfsr_d;
  logic [23:0]             cnt_q, cnt_d;
  logic [23:0]             period_q, period_d;
  logic [LANES-1:0]        btn_prev_q;

  logic [LANES-1:0]        press;
  logic [LANES-1:0]        hit_row;
  logic [LANES-1:0]        hitmask;
  logic [LANES-1:0]        new_row;
  logic                    wrong;
  logic                    tick;
  logic                    miss;
  logic [7:0]              lfsr_next;
  logic [SCORE_W:0]        hit_cnt;
  logic [SCORE_W:0]        score_sum;
  logic [SCORE_W-1:0]      score_sat;
  logic                    speedup;
  logic [24:0]             floor_sum;
  logic [23:0]             period_dec;

  // Rising edges only, so a held key counts as a single press.
  assign press   = btn & ~btn_prev_q;
  assign hit_row = tiles_q[HIT_LO +: LANES];
  assign hitmask = press & hit_row;
  assign wrong   = |(press & ~hit_row);
  assign tick    = (cnt_q >= (period_q - 24'd1));
  assign miss    = tick & (|(hit_row & ~hitmask));

  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    new_row = '0;
    new_row[lfsr_next[LW-1:0]] = 1'b1;
  end

  always_comb begin
    hit_cnt = '0;
    for (int l = 0; l < LANES; l++) begin
      hit_cnt = hit_cnt + (SCORE_W+1)'(hitmask[l]);
    end
  end

  assign score_sum = {1'b0, score_q} + hit_cnt;
  assign score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  assign speedup   = (score_sat[SCORE_W-1:SPW] != score_q[SCORE_W-1:SPW]);

  // Compare against MIN+STEP in 25 bits so the subtraction can never wrap.
  assign floor_sum  = {1'b0, SCROLL_MIN} + {1'b0, SCROLL_STEP};
  assign period_dec = ({1'b0, period_q} > floor_sum) ? (period_q - SCROLL_STEP) : SCROLL_MIN;

  always_comb begin
    state_d  = state_q;
    tiles_d  = tiles_q;
    score_d  = score_q;
    scroll_d = 1'b0;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (state_q == ST_IDLE) begin
          tiles_d = '0;
        end
        if (start) begin
          state_d  = ST_PLAY;
          tiles_d  = '0;
          score_d  = '0;
          cnt_d    = '0;
          period_d = SCROLL_DIV;
        end
      end
      ST_PLAY: begin
        // A wrong press or a miss ends the game with board, score and LFSR frozen.
        if (wrong || miss) begin
          state_d = ST_OVER;
        end else begin
          score_d = score_sat;
          if (speedup) begin
            period_d = period_dec;
          end
          if (tick) begin
            cnt_d    = '0;
            lfsr_d   = lfsr_next;
            tiles_d  = {tiles_q[HIT_LO-1:0], new_row};
            scroll_d = 1'b1;
          end else begin
            cnt_d                    = cnt_q + 24'd1;
            tiles_d[HIT_LO +: LANES] = hit_row & ~hitmask;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tiles_q    <= '0;
      score_q    <= '0;
      scroll_q   <= 1'b0;
      lfsr_q     <= 8'hA5;
      cnt_q      <= '0;
      period_q   <= SCROLL_DIV;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      tiles_q    <= tiles_d;
      score_q    <= score_d;
      scroll_q   <= scroll_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      btn_prev_q <= btn;
    end
  end

  assign tiles        = tiles_q;
  assign score        = score_q;
  assign scroll_pulse = scroll_q;
  assign playing      = (state_q == ST_PLAY);
  assign game_over    = (state_q == ST_OVER);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_tile_board_engine.sv
// Directed bench for tile_board_engine: scroll timing, tile sequence, hits,
// misses, wrong presses, speed-up floor, restart and reset behaviour.
module tb_tile_board_engine;

  localparam int          LANES         = 4;
  localparam int          ROWS          = 5;
  localparam logic [23:0] SCROLL_DIV    = 24'd4;
  localparam logic [23:0] SCROLL_MIN    = 24'd2;
  localparam logic [23:0] SCROLL_STEP   = 24'd1;
  localparam int          SPEEDUP_EVERY = 2;
  localparam int          SCORE_W       = 10;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [LANES-1:0]      btn = '0;
  logic                  start = 1'b0;
  logic [LANES*ROWS-1:0] tiles;
  logic [SCORE_W-1:0]    score;
  logic                  playing;
  logic                  game_over;
  logic                  scroll_pulse;
  logic [1:0]            dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc;

  tile_board_engine #(
    .LANES(LANES), .ROWS(ROWS), .SCROLL_DIV(SCROLL_DIV), .SCROLL_MIN(SCROLL_MIN),
    .SCROLL_STEP(SCROLL_STEP), .SPEEDUP_EVERY(SPEEDUP_EVERY), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .start(start), .tiles(tiles), .score(score),
    .playing(playing), .game_over(game_over), .scroll_pulse(scroll_pulse),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    btn   = '0;
    tick_n(2);
    rst_n = 1'b1;
  endtask

  task automatic start_game();
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
  endtask

  task automatic wait_scroll(input int limit, output int cycles);
    cycles = 0;
    do begin
      tick_n(1);
      cycles++;
    end while (!scroll_pulse && !game_over && cycles < limit);
    check_eq("scroll_or_over_seen", {31'd0, scroll_pulse | game_over}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] exp_a [0:3];
    exp_a[0] = 20'h00042;
    exp_a[1] = 20'h00424;
    exp_a[2] = 20'h04241;
    exp_a[3] = 20'h42412;

    // Reset and idle behaviour
    do_reset();
    check_eq("rst_tiles", 32'(tiles), 32'h0);
    check_eq("rst_score", 32'(score), 32'h0);
    check_eq("rst_playing", 32'(playing), 32'h0);
    check_eq("rst_game_over", 32'(game_over), 32'h0);
    check_eq("rst_scroll", 32'(scroll_pulse), 32'h0);
    check_eq("rst_state", 32'(dbg_state), 32'h0);
    btn = 4'b0101;
    tick_n(2);
    check_eq("idle_tiles", 32'(tiles), 32'h0);
    check_eq("idle_playing", 32'(playing), 32'h0);
    btn = '0;
    tick_n(1);

    // Game A: first scroll timing, start ignored in PLAY, then a miss
    start_game();
    check_eq("a_playing", 32'(playing), 32'h1);
    check_eq("a_entry_tiles", 32'(tiles), 32'h0);
    tick_n(1);
    check_eq("a_sp_c1", 32'(scroll_pulse), 32'h0);
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
    check_eq("a_sp_c2", 32'(scroll_pulse), 32'h0);
    tick_n(1);
    check_eq("a_sp_c3", 32'(scroll_pulse), 32'h0);
    tick_n(1);
    check_eq("a_first_scroll", 32'(scroll_pulse), 32'h1);
    check_eq("a_first_tile", 32'(tiles), 32'h00004);
    for (int i = 0; i < 4; i++) begin
      wait_scroll(10, cyc);
      check_eq($sformatf("a_interval_%0d", i + 2), 32'(cyc), 32'd4);
      check_eq($sformatf("a_tiles_%0d", i + 2), 32'(tiles), 32'(exp_a[i]));
    end
    check_eq("a_no_over_yet", 32'(game_over), 32'h0);
    wait_scroll(10, cyc);
    check_eq("a_miss_interval", 32'(cyc), 32'd4);
    check_eq("a_miss_over", 32'(game_over), 32'h1);
    check_eq("a_miss_playing", 32'(playing), 32'h0);
    check_eq("a_miss_tiles", 32'(tiles), 32'h42412);
    check_eq("a_miss_score", 32'(score), 32'h0);
    check_eq("a_miss_state", 32'(dbg_state), 32'h2);
    btn = 4'b0100;
    tick_n(3);
    btn = '0;
    check_eq("a_over_tiles_frozen", 32'(tiles), 32'h42412);
    check_eq("a_over_score_frozen", 32'(score), 32'h0);
    check_eq("a_over_sp", 32'(scroll_pulse), 32'h0);

    // Game B: hits, held key, exact-scroll hit, speed-ups, floor, wrong+scroll
    do_reset();
    start_game();
    for (int i = 0; i < 5; i++) wait_scroll(10, cyc);
    check_eq("b_s5_tiles", 32'(tiles), 32'h42412);
    btn = 4'b0100;
    tick_n(1);
    check_eq("b_hit_tiles", 32'(tiles), 32'h02412);
    check_eq("b_hit_score", 32'(score), 32'd1);
    check_eq("b_hit_over", 32'(game_over), 32'h0);
    tick_n(2);
    check_eq("b_hold_score", 32'(score), 32'd1);
    check_eq("b_hold_over", 32'(game_over), 32'h0);
    tick_n(1);
    check_eq("b_s6_sp", 32'(scroll_pulse), 32'h1);
    check_eq("b_s6_tiles", 32'(tiles), 32'h24128);
    check_eq("b_s6_score", 32'(score), 32'd1);
    btn = 4'b0110;
    tick_n(1);
    check_eq("b_hit2_score", 32'(score), 32'd2);
    check_eq("b_hit2_tiles", 32'(tiles), 32'h04128);
    btn = 4'b0000;
    tick_n(1);
    check_eq("b_p3_sp_c2", 32'(scroll_pulse), 32'h0);
    tick_n(1);
    check_eq("b_p3_scroll", 32'(scroll_pulse), 32'h1);
    check_eq("b_s7_tiles", 32'(tiles), 32'h41288);
    tick_n(2);
    check_eq("b_s8_pre_sp", 32'(scroll_pulse), 32'h0);
    btn = 4'b0100;
    tick_n(1);
    check_eq("b_edge_hit_sp", 32'(scroll_pulse), 32'h1);
    check_eq("b_edge_hit_score", 32'(score), 32'd3);
    check_eq("b_edge_hit_tiles", 32'(tiles), 32'h12884);
    check_eq("b_edge_hit_over", 32'(game_over), 32'h0);
    btn = 4'b0001;
    tick_n(1);
    check_eq("b_hit4_score", 32'(score), 32'd4);
    check_eq("b_hit4_tiles", 32'(tiles), 32'h02884);
    tick_n(1);
    check_eq("b_p2_scroll", 32'(scroll_pulse), 32'h1);
    check_eq("b_s9_tiles", 32'(tiles), 32'h28842);
    btn = 4'b0010;
    tick_n(1);
    check_eq("b_hit5_score", 32'(score), 32'd5);
    check_eq("b_hit5_tiles", 32'(tiles), 32'h08842);
    tick_n(1);
    check_eq("b_s10_sp", 32'(scroll_pulse), 32'h1);
    check_eq("b_s10_tiles", 32'(tiles), 32'h88428);
    btn = 4'b1000;
    tick_n(1);
    check_eq("b_hit6_score", 32'(score), 32'd6);
    check_eq("b_hit6_tiles", 32'(tiles), 32'h08428);
    tick_n(1);
    check_eq("b_s11_sp", 32'(scroll_pulse), 32'h1);
    check_eq("b_s11_tiles", 32'(tiles), 32'h84288);
    btn = 4'b0000;
    tick_n(1);
    check_eq("b_floor_sp", 32'(scroll_pulse), 32'h0);
    btn = 4'b1001;
    tick_n(1);
    btn = 4'b0000;
    check_eq("b_wrong_scroll_over", 32'(game_over), 32'h1);
    check_eq("b_wrong_scroll_score", 32'(score), 32'd6);
    check_eq("b_wrong_scroll_tiles", 32'(tiles), 32'h84288);
    check_eq("b_wrong_scroll_sp", 32'(scroll_pulse), 32'h0);

    // Restart from OVER clears board, score and period
    tick_n(2);
    start_game();
    check_eq("b_restart_playing", 32'(playing), 32'h1);
    check_eq("b_restart_tiles", 32'(tiles), 32'h0);
    check_eq("b_restart_score", 32'(score), 32'h0);
    wait_scroll(10, cyc);
    check_eq("b_restart_period", 32'(cyc), 32'd4);
    check_eq("b_restart_upper_rows", 32'(tiles[19:4]), 32'h0);

    // Game C: reset mid-PLAY, wrong press, LFSR carried across restart
    tick_n(1);
    rst_n = 1'b0;
    tick_n(1);
    check_eq("c_rst_tiles", 32'(tiles), 32'h0);
    check_eq("c_rst_score", 32'(score), 32'h0);
    check_eq("c_rst_playing", 32'(playing), 32'h0);
    check_eq("c_rst_state", 32'(dbg_state), 32'h0);
    rst_n = 1'b1;
    start_game();
    wait_scroll(10, cyc);
    check_eq("c_first_interval", 32'(cyc), 32'd4);
    check_eq("c_first_tile", 32'(tiles), 32'h00004);
    for (int i = 0; i < 4; i++) wait_scroll(10, cyc);
    check_eq("c_s5_tiles", 32'(tiles), 32'h42412);
    btn = 4'b0001;
    tick_n(1);
    btn = 4'b0000;
    check_eq("c_wrong_over", 32'(game_over), 32'h1);
    check_eq("c_wrong_score", 32'(score), 32'h0);
    check_eq("c_wrong_tiles", 32'(tiles), 32'h42412);
    tick_n(1);
    start_game();
    check_eq("c_restart_tiles", 32'(tiles), 32'h0);
    wait_scroll(10, cyc);
    check_eq("c_restart_interval", 32'(cyc), 32'd4);
    check_eq("c_no_reseed_tile", 32'(tiles), 32'h00008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
